// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions for pipeline Stage 0: fetch states, the PC select
// encoding and the layout of the Stage 0 buffer that the decoder slices.
package instruction_fetch_unit_pkg;

  localparam int INSTRBITWIDTH = 16;
  localparam int DATABITWIDTH_DEF = 16;
  localparam logic [15:0] RESETVECTOR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL,
    HALTED
  } FetchState_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD
  } PcSel_t;

  // Buffer layout, MSB first: {valid, instruction, pc}
  function automatic int stage0BufferWidth(input int dataBitWidth);
    return 1 + INSTRBITWIDTH + dataBitWidth;
  endfunction

  localparam int STAGE0_BUFFER_WIDTH = stage0BufferWidth(DATABITWIDTH_DEF);

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: control requests from later stages, the instruction ROM
// port and the registered Stage 0 buffer outputs.
interface instruction_fetch_unit_if #(
  parameter int DATABITWIDTH = 16
);

  logic                    SystemEn;
  logic                    StallEn;
  logic                    BranchValid;
  logic [DATABITWIDTH-1:0] BranchTarget;
  logic                    HaltReq;
  logic [DATABITWIDTH-1:0] InstructionAddress;
  logic [15:0]             InstructionIn;
  logic                    FetchValid;
  logic [15:0]             FetchInstruction;
  logic [DATABITWIDTH-1:0] FetchPC;
  logic                    FetchFlush;
  logic                    HaltOut;
  logic [15:0]             FetchCount;

  modport master (
    input  SystemEn, StallEn, BranchValid, BranchTarget, HaltReq, InstructionIn,
    output InstructionAddress, FetchValid, FetchInstruction, FetchPC,
           FetchFlush, HaltOut, FetchCount
  );

  modport slave (
    output SystemEn, StallEn, BranchValid, BranchTarget, HaltReq, InstructionIn,
    input  InstructionAddress, FetchValid, FetchInstruction, FetchPC,
           FetchFlush, HaltOut, FetchCount
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// Program counter register with hold / increment / load-target select.
// Increment wraps naturally at 2^DATABITWIDTH.
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATABITWIDTH = DATABITWIDTH_DEF,
  parameter logic [DATABITWIDTH-1:0] RESETVECTOR = '0
) (
  input  logic                    clk,
  input  logic                    sync_rst_n,
  input  logic                    clk_en,
  input  PcSel_t                  pcSel,
  input  logic [DATABITWIDTH-1:0] branchTarget,
  output logic [DATABITWIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      pc <= RESETVECTOR;
    end else if (clk_en) begin
      case (pcSel)
        PC_INC:  pc <= pc + DATABITWIDTH'(1);
        PC_LOAD: pc <= branchTarget;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Pipeline Stage 0: run/stall/redirect/halt control, the registered Stage 0
// buffer {valid, instruction, pc}, the redirect flush pulse and a fetch counter.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATABITWIDTH = DATABITWIDTH_DEF,
  parameter logic [DATABITWIDTH-1:0] RESETVECTOR = DATABITWIDTH'(RESETVECTOR_DEF)
) (
  input logic                     clk,
  input logic                     sync_rst_n,
  input logic                     clk_en,
  instruction_fetch_unit_if.master fetchBus
);

  localparam int BUFW = stage0BufferWidth(DATABITWIDTH);

  FetchState_t             state, stateNext;
  logic [BUFW-1:0]         stage0Buf, stage0BufNext;
  logic                    flush, flushNext;
  logic [15:0]             count, countNext;
  PcSel_t                  pcSel;
  logic [DATABITWIDTH-1:0] pc;

  fetch_pc_reg #(
    .DATABITWIDTH(DATABITWIDTH),
    .RESETVECTOR (RESETVECTOR)
  ) pcReg (
    .clk         (clk),
    .sync_rst_n  (sync_rst_n),
    .clk_en      (clk_en),
    .pcSel       (pcSel),
    .branchTarget(fetchBus.BranchTarget),
    .pc          (pc)
  );

  // Losing SystemEn stops fetching outright; otherwise branch > halt > stall > fetch.
  always_comb begin
    stateNext     = state;
    stage0BufNext = stage0Buf;
    flushNext     = 1'b0;
    countNext     = count;
    pcSel         = PC_HOLD;
    case (state)
      IDLE: begin
        stage0BufNext[BUFW-1] = 1'b0;
        if (fetchBus.SystemEn) stateNext = RUN;
      end
      RUN, STALL: begin
        if (!fetchBus.SystemEn) begin
          stateNext             = IDLE;
          stage0BufNext[BUFW-1] = 1'b0;
        end else if (fetchBus.BranchValid) begin
          pcSel                 = PC_LOAD;
          stage0BufNext[BUFW-1] = 1'b0;
          flushNext             = 1'b1;
          stateNext             = fetchBus.HaltReq ? HALTED : RUN;
        end else if (fetchBus.HaltReq) begin
          stateNext             = HALTED;
          stage0BufNext[BUFW-1] = 1'b0;
        end else if (fetchBus.StallEn) begin
          stateNext = STALL;
        end else if (state == STALL) begin
          stateNext = RUN;
        end else begin
          stage0BufNext = {1'b1, fetchBus.InstructionIn, pc};
          pcSel         = PC_INC;
          countNext     = (count == 16'hFFFF) ? count : count + 16'd1;
        end
      end
      HALTED: begin
        stage0BufNext[BUFW-1] = 1'b0;
        if (!fetchBus.SystemEn) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state     <= IDLE;
      stage0Buf <= '0;
      flush     <= 1'b0;
      count     <= '0;
    end else if (clk_en) begin
      state     <= stateNext;
      stage0Buf <= stage0BufNext;
      flush     <= flushNext;
      count     <= countNext;
    end
  end

  assign fetchBus.InstructionAddress = pc;
  assign fetchBus.FetchValid         = stage0Buf[BUFW-1];
  assign fetchBus.FetchInstruction   = stage0Buf[BUFW-2 -: INSTRBITWIDTH];
  assign fetchBus.FetchPC            = stage0Buf[DATABITWIDTH-1:0];
  assign fetchBus.FetchFlush         = flush;
  assign fetchBus.HaltOut            = (state == HALTED);
  assign fetchBus.FetchCount         = count;

endmodule
